// File: rtl/dvp_frame_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dvp_frame_gen_if : DVP camera bus plus external-pixel request handshake
// Rev 1.0
// ---------------------------------------------------------------------------
interface dvp_frame_gen_if;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        pix_req;
  logic [23:0] pix_in;

  modport master (output vsync, output href, output data, output pix_req, input pix_in);
  modport slave  (input vsync, input href, input data, input pix_req, output pix_in);
endinterface
`default_nettype wire

// File: rtl/dvp_frame_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dvp_frame_gen : parametrised DVP frame source (bars / ramp / external pixels)
// Rev 1.0
// ---------------------------------------------------------------------------
module dvp_frame_gen #(
  parameter int WIDTH      = 512,
  parameter int HEIGHT     = 512,
  parameter int VSYNC_CYC  = 10,
  parameter int VBP_CYC    = 20,
  parameter int HBLANK_CYC = 10,
  parameter int VFP_CYC    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic [1:0] mode,
  input  logic [1:0] pattern,
  output logic       busy,
  output logic       frame_done,
  dvp_frame_gen_if.master dvp
);

  localparam int C_M1      = (VSYNC_CYC > VBP_CYC) ? VSYNC_CYC : VBP_CYC;
  localparam int C_M2      = (HBLANK_CYC > VFP_CYC) ? HBLANK_CYC : VFP_CYC;
  localparam int C_CNT_MAX = ((C_M1 > C_M2) ? C_M1 : C_M2) - 1;
  localparam int CW        = (C_CNT_MAX < 1) ? 1 : $clog2(C_CNT_MAX + 1);
  localparam int XW        = $clog2(WIDTH);
  localparam int YW        = (HEIGHT < 2) ? 1 : $clog2(HEIGHT);
  localparam int BAR_W     = WIDTH / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFP    = 3'd5;

  localparam logic [1:0] P_EXT = 2'd2;

  logic [2:0]    r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic [1:0]    r_b, w_b;
  logic [1:0]    r_mode, w_mode;
  logic [1:0]    r_pat, w_pat;
  logic [23:0]   r_pix, w_pix;
  logic [2:0]    w_bar;
  logic [7:0]    w_ramp, w_byte;
  logic          r_vsync, r_href, r_pix_req, r_busy, r_frame_done;
  logic [7:0]    r_data;
  logic          w_pix_req;

  function automatic logic [1:0] last_byte(input logic [1:0] m);
    case (m)
      2'd1:    return 2'd1;
      2'd2:    return 2'd0;
      default: return 2'd2;
    endcase
  endfunction

  // Counters are advanced in the next-state view so every output can be registered.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_x     = r_x;
    w_y     = r_y;
    w_b     = r_b;
    w_mode  = r_mode;
    w_pat   = r_pat;
    case (r_state)
      S_IDLE: if (start) begin
        w_state = S_VSYNC;
        w_cnt   = '0;
        w_mode  = (mode == 2'd3) ? 2'd0 : mode;
        w_pat   = (pattern == 2'd3) ? 2'd0 : pattern;
      end
      S_VSYNC: if (r_cnt == CW'(VSYNC_CYC - 1)) begin
        w_state = S_VBP;
        w_cnt   = '0;
      end else w_cnt = r_cnt + 1'b1;
      S_VBP: if (r_cnt == CW'(VBP_CYC - 1)) begin
        w_state = S_LINE;
        w_cnt   = '0;
        w_x     = '0;
        w_y     = '0;
        w_b     = '0;
      end else w_cnt = r_cnt + 1'b1;
      S_LINE: if (r_b == last_byte(r_mode)) begin
        w_b = '0;
        if (r_x == XW'(WIDTH - 1)) begin
          w_x   = '0;
          w_cnt = '0;
          if (r_y == YW'(HEIGHT - 1)) begin
            w_state = S_VFP;
            w_y     = '0;
          end else begin
            w_state = S_HBLANK;
            w_y     = r_y + 1'b1;
          end
        end else w_x = r_x + 1'b1;
      end else w_b = r_b + 1'b1;
      S_HBLANK: if (r_cnt == CW'(HBLANK_CYC - 1)) begin
        w_state = S_LINE;
        w_cnt   = '0;
      end else w_cnt = r_cnt + 1'b1;
      S_VFP: if (r_cnt == CW'(VFP_CYC - 1)) begin
        w_cnt = '0;
        if (continuous) begin
          w_state = S_VSYNC;
          w_mode  = (mode == 2'd3) ? 2'd0 : mode;
          w_pat   = (pattern == 2'd3) ? 2'd0 : pattern;
        end else w_state = S_IDLE;
      end else w_cnt = r_cnt + 1'b1;
      default: w_state = S_IDLE;
    endcase
  end

  // An external pixel's first byte is taken straight from pix_in on its capture edge.
  always_comb begin
    w_bar  = 3'(w_x / XW'(BAR_W));
    w_ramp = 8'(w_x) + 8'(w_y);
    w_pix  = 24'h000000;
    if (w_pat == P_EXT) w_pix = r_pix_req ? dvp.pix_in : r_pix;
    else if (w_pat == 2'd1) w_pix = {w_ramp, w_ramp, w_ramp};
    else begin
      case (w_bar)
        3'd0:    w_pix = 24'hFFFFFF;
        3'd1:    w_pix = 24'hFFFF00;
        3'd2:    w_pix = 24'h00FFFF;
        3'd3:    w_pix = 24'h00FF00;
        3'd4:    w_pix = 24'hFF00FF;
        3'd5:    w_pix = 24'hFF0000;
        3'd6:    w_pix = 24'h0000FF;
        default: w_pix = 24'h000000;
      endcase
    end
    case (w_mode)
      2'd1:    w_byte = (w_b == 2'd0) ? {w_pix[23:19], w_pix[15:13]} : {w_pix[12:10], w_pix[7:3]};
      2'd2:    w_byte = w_pix[15:8];
      default: w_byte = (w_b == 2'd0) ? w_pix[23:16] : ((w_b == 2'd1) ? w_pix[15:8] : w_pix[7:0]);
    endcase
    w_pix_req = (w_pat == P_EXT) &&
                ((w_state == S_VBP    && w_cnt == CW'(VBP_CYC - 1)) ||
                 (w_state == S_HBLANK && w_cnt == CW'(HBLANK_CYC - 1)) ||
                 (w_state == S_LINE   && w_b == last_byte(w_mode) && w_x != XW'(WIDTH - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_b          <= '0;
      r_mode       <= '0;
      r_pat        <= '0;
      r_pix        <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= '0;
      r_pix_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_x          <= w_x;
      r_y          <= w_y;
      r_b          <= w_b;
      r_mode       <= w_mode;
      r_pat        <= w_pat;
      if (r_pix_req) r_pix <= dvp.pix_in;
      r_vsync      <= (w_state == S_VSYNC);
      r_href       <= (w_state == S_LINE);
      r_data       <= (w_state == S_LINE) ? w_byte : 8'h00;
      r_pix_req    <= w_pix_req;
      r_busy       <= (w_state != S_IDLE);
      r_frame_done <= (w_state == S_VFP) && (w_cnt == CW'(VFP_CYC - 1));
    end
  end

  assign dvp.vsync   = r_vsync;
  assign dvp.href    = r_href;
  assign dvp.data    = r_data;
  assign dvp.pix_req = r_pix_req;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_dvp_frame_gen : scoreboard bench for dvp_frame_gen on a 16x2 frame
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dvp_frame_gen;
  localparam int W = 16, H = 2, VS = 2, VBP = 3, HB = 4, VFP = 5;

  logic       clk = 1'b0;
  logic       rst, start, continuous;
  logic [1:0] mode, pattern;
  logic       busy, frame_done;
  int         checks = 0;
  int         errors = 0;
  int         ext_x  = 0;
  logic [7:0] exp_q[$];

  dvp_frame_gen_if bus ();

  dvp_frame_gen #(.WIDTH(W), .HEIGHT(H), .VSYNC_CYC(VS), .VBP_CYC(VBP),
                  .HBLANK_CYC(HB), .VFP_CYC(VFP)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .mode(mode), .pattern(pattern), .busy(busy), .frame_done(frame_done),
    .dvp(bus.master)
  );

  always #5 clk = ~clk;

  // External pixel source answers each request with {00, x*17, 00}.
  always @(negedge clk) begin
    if (bus.pix_req === 1'b1) begin
      bus.pix_in = {8'h00, 8'((ext_x * 17) & 255), 8'h00};
      ext_x      = (ext_x + 1) % W;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int bpp_of(input int m);
    return (m == 1) ? 2 : ((m == 2) ? 1 : 3);
  endfunction

  function automatic int frame_len(input int bpp);
    return VS + VBP + H * W * bpp + (H - 1) * HB + VFP;
  endfunction

  // Position inside the active line for frame cycle k, or -1 outside href.
  function automatic int line_pos(input int k, input int bpp);
    int t, per, l, r;
    t = k - (VS + VBP + 1);
    if (t < 0) return -1;
    per = W * bpp + HB;
    l = t / per;
    r = t % per;
    if (l >= H || r >= W * bpp) return -1;
    return r;
  endfunction

  function automatic logic [23:0] model_pix(input int p, input int x, input int y);
    logic [7:0] v;
    if (p == 1) begin
      v = 8'((x + y) & 255);
      return {v, v, v};
    end
    if (p == 2) return {8'h00, 8'((x * 17) & 255), 8'h00};
    case (x / (W / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [7:0] model_byte(input int m, input logic [23:0] px, input int b);
    if (m == 1) return (b == 0) ? {px[23:19], px[15:13]} : {px[12:10], px[7:3]};
    if (m == 2) return px[15:8];
    return (b == 0) ? px[23:16] : ((b == 1) ? px[15:8] : px[7:0]);
  endfunction

  task automatic push_frame(input int m, input int p);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int b = 0; b < bpp_of(m); b++)
          exp_q.push_back(model_byte(m, model_pix(p, x, y), b));
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({bus.vsync, bus.href, bus.data, bus.pix_req, busy, frame_done} !== 13'd0) begin
      errors++;
      $display("FAIL %s: vsync/href/data/pix_req/busy/frame_done = %b/%b/%h/%b/%b/%b, required all 0",
               name, bus.vsync, bus.href, bus.data, bus.pix_req, busy, frame_done);
    end
  endtask

  // Called at a negedge with start (or continuation) taking effect on the next posedge.
  task automatic check_frame(input string name, input int m, input int p,
                             input int extra_start_k, input int drop_cont_k);
    int bpp, total, r, rn;
    logic [7:0] exp_d;
    logic exp_req;
    bpp   = bpp_of(m);
    total = frame_len(bpp);
    push_frame(m, p);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == extra_start_k) start = 1'b1;
      else if (k == extra_start_k + 1) start = 1'b0;
      if (k == drop_cont_k) continuous = 1'b0;
      r  = line_pos(k, bpp);
      rn = line_pos(k + 1, bpp);
      exp_d = 8'h00;
      if (r >= 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard k=%0d: byte produced, none expected", name, k);
        end else exp_d = exp_q.pop_front();
      end
      exp_req = (p == 2) && (rn >= 0) && (rn % bpp == 0);
      checks++;
      if (bus.vsync !== 1'(k <= VS)) begin
        errors++;
        $display("FAIL %s vsync k=%0d: got %b, required %b", name, k, bus.vsync, k <= VS);
      end
      checks++;
      if (bus.href !== 1'(r >= 0)) begin
        errors++;
        $display("FAIL %s href k=%0d: got %b, required %b", name, k, bus.href, r >= 0);
      end
      checks++;
      if (bus.data !== exp_d) begin
        errors++;
        $display("FAIL %s data k=%0d: got %h, required %h", name, k, bus.data, exp_d);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy k=%0d: got %b, required 1", name, k, busy);
      end
      checks++;
      if (frame_done !== 1'(k == total)) begin
        errors++;
        $display("FAIL %s frame_done k=%0d: got %b, required %b", name, k, frame_done, k == total);
      end
      checks++;
      if (bus.pix_req !== exp_req) begin
        errors++;
        $display("FAIL %s pix_req k=%0d: got %b, required %b", name, k, bus.pix_req, exp_req);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s scoreboard leftover: got %0d bytes unsent, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; continuous = 1'b0; mode = 2'd0; pattern = 2'd0;
    bus.pix_in = 24'h0;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle("reset_release");
    end
  endtask

  task automatic run_single(input string name, input int m, input int p);
    mode = 2'(m); pattern = 2'(p); continuous = 1'b0; ext_x = 0;
    start = 1'b1;
    check_frame(name, m, p, 0, 0);
    @(negedge clk);
    check_idle({name, "_end"});
  endtask

  task automatic test_rgb888_bars();
    run_single("rgb888_bars", 0, 0);
  endtask

  task automatic test_rgb565_ramp();
    run_single("rgb565_ramp", 1, 1);
  endtask

  task automatic test_grey_external();
    run_single("grey_ext", 2, 2);
  endtask

  task automatic test_continuous();
    mode = 2'd1; pattern = 2'd0; continuous = 1'b1;
    start = 1'b1;
    check_frame("cont_f1", 1, 0, 40, 0);
    check_frame("cont_f2", 1, 0, 0, 30);
    repeat (2) begin
      @(negedge clk);
      check_idle("cont_end");
    end
  endtask

  task automatic test_reset_midline();
    mode = 2'd0; pattern = 2'd0; continuous = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= VS + VBP + 11; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    checks++;
    if (bus.href !== 1'b1 || bus.data !== 8'hFF) begin
      errors++;
      $display("FAIL midline_pre: href/data = %b/%h, required 1/ff", bus.href, bus.data);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("midline_rst");
    rst = 1'b0;
    @(negedge clk);
    check_idle("midline_idle");
    mode = 2'd3; pattern = 2'd3;
    start = 1'b1;
    check_frame("after_rst_reserved", 3, 3, 0, 0);
    @(negedge clk);
    check_idle("after_rst_end");
  endtask

  initial begin
    test_reset();
    test_rgb888_bars();
    test_rgb565_ramp();
    test_grey_external();
    test_continuous();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dvp_frame_gen.md
# dvp_frame_gen

Synthesizable, parametrised DVP camera-source model that drives the encoder's camera input port (`vsync`, `href`, 8-bit `data`) with full frames. It produces the frame and line timing that the encoder expects and supports three byte formats and three pixel sources. It sits ahead of `top` on FPGA bring-up boards and in regression benches, and replaces file-driven stimulus.

## Interface
- `WIDTH`, 512: pixels per line; must be ≥8 and a multiple of 8.
- `HEIGHT`, 512: lines per frame; ≥1.
- `VSYNC_CYC`, 10: vsync high duration in cycles; ≥1.
- `VBP_CYC`, 20: cycles from vsync fall to the first href rise; ≥1.
- `HBLANK_CYC`, 10: href-low cycles between lines; ≥1.
- `VFP_CYC`, 20: cycles after the last line before frame end; ≥1.
- `clk`  in  1  pixel clock; the single clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request one frame; honoured only in IDLE.
- `continuous`  in  1  when sampled high at frame end, start the next frame immediately.
- `mode`  in  2  byte format: 0 = RGB888 (3 B/px: R, G, B); 1 = RGB565 (2 B/px, high byte first); 2 = grey (1 B/px, G); 3 is reserved and treated as 0.
- `pattern`  in  2  pixel source: 0 = colour bars; 1 = ramp; 2 = external (`pix_in`); 3 is treated as 0.
- `pix_in`  in  24  external pixel {R,G,B}; must be valid while `pix_req`=1.
- `pix_req`  out  1  external pixel is consumed at this clock edge.
- `vsync`  out  1  frame sync.
- `href`  out  1  line valid.
- `data`  out  8  pixel byte; 0 whenever `href`=0.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on the last VFP cycle.

## Operation
- FSM states: IDLE, VSYNC, VBP, LINE, HBLANK, VFP.
- IDLE → VSYNC when `start`=1. `mode` and `pattern` are latched on that edge and held for the whole frame.
- VSYNC (`VSYNC_CYC` cycles) → VBP (`VBP_CYC`) → LINE.
- LINE lasts `WIDTH`·BPP cycles, where BPP = 3, 2 or 1 by mode.
- After LINE: go to HBLANK (`HBLANK_CYC`) → LINE for lines 0..HEIGHT-2. After line HEIGHT-1, go to VFP instead.
- VFP (`VFP_CYC`) → VSYNC if `continuous`=1 on the last VFP cycle (mode/pattern re-latched), else IDLE.
- `start` is ignored while `busy`=1.
- Internal counters: cycle counter per state, x (0..WIDTH-1), byte index (0..BPP-1), y (0..HEIGHT-1). Widths are `$clog2` of the maximum value + 1. No wrap beyond terminal counts.
- Colour bars: bar = x / (WIDTH/8). Bars 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Ramp: R = G = B = (x + y)[7:0].
- External source: pixel captured from `pix_in` on the edge where `pix_req`=1. `pix_req` is high exactly one cycle before each pixel's first byte, and never high for patterns 0 and 1.
- RGB565 bytes: {R[7:3],G[7:5]}, then {G[4:2],B[7:3]}.

## Timing
- All outputs are registered.
- Reset values: `vsync`=0, `href`=0, `data`=0, `pix_req`=0, `busy`=0, `frame_done`=0; FSM in IDLE; all counters 0.
- `start` high at edge N: `vsync`=1 and `busy`=1 from cycle N+1 through N+`VSYNC_CYC`.
- First href rise: cycle N+1+`VSYNC_CYC`+`VBP_CYC`. First byte is valid in the same cycle.
- `data` changes once per cycle while `href`=1. Byte k of pixel x is on the bus in LINE cycle x·BPP+k.
- Total frame length (start to frame_done, inclusive): `VSYNC_CYC`+`VBP_CYC`+HEIGHT·WIDTH·BPP+(HEIGHT-1)·`HBLANK_CYC`+`VFP_CYC` cycles.
- `frame_done` and the return to IDLE coincide. `busy` falls the cycle after `frame_done` unless continuing.
- In continuous mode, `vsync` rises the cycle after `frame_done`, with no IDLE gap.
- `rst` asserted in any state, including mid-line: all outputs return to reset values on the next cycle. No partial line completes.
- `rst` and `start` high together: reset wins.

## Test plan
- **Reset:** hold `rst` 3 cycles. → All outputs 0; `busy`=0; `start` in the same cycle as `rst` is ignored.
- **RGB888 bars:** WIDTH=16, HEIGHT=2, VSYNC 2 / VBP 3 / HBLANK 4 / VFP 5, `mode`=0, `pattern`=0, pulse `start`. → vsync high 2 cycles; href rises 3 cycles later and is high 48 cycles.
  - Bytes: FF,FF,FF ×2 px, then FF,FF,00 ×2 px, …, ending 00,00,00.
  - href low 4 cycles, then line 2 repeats line 1.
  - `frame_done` at cycle 2+3+96+4+5 = 110 after start.
- **RGB565 ramp:** same geometry, `mode`=1, `pattern`=1. → href high 32 cycles per line. Line 1, pixel x=3 gives bytes 0x00, 0x00; line 2, x=7 (value 8) gives 0x08, 0x41.
- **Grey external:** `mode`=2, `pattern`=2, `pix_in` = {8'h00, x·17, 8'h00} driven in response to `pix_req`. → 16 `pix_req` pulses per line, each one cycle before its byte; `data` = 0x00, 0x11, …, 0xFF.
- **Continuous and busy:** `continuous`=1 over 2 frames, with `start` pulsed mid-frame. → Second vsync the cycle after `frame_done`; extra `start` has no effect. Drop `continuous` during frame 2 → IDLE after its `frame_done`.
- **Reset mid-line:** assert `rst` at LINE cycle 10. → Next cycle: href=0, data=0, busy=0. A fresh `start` reproduces the frame from pixel 0.
